vga_timing_monitor: RTL

VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

---
 rtl/vga_timing_monitor_if.sv | 26 ++
 rtl/vga_timing_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor_if.sv
// vga_timing_monitor_if: VGA sync/colour stream plus the monitor's recovered
// timing results. The generator side is the master, the monitor is the slave.
interface vga_timing_monitor_if;
    logic        h_sync;
    logic        v_sync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic [9:0]  x_loc;
    logic [9:0]  y_loc;
    logic        pix_valid;
    logic        locked;
    logic        frame_done;
    logic [7:0]  err_count;
    logic [15:0] checksum;

    modport master (
        output h_sync, v_sync, red, green, blue,
        input  x_loc, y_loc, pix_valid, locked, frame_done, err_count, checksum
    );

    modport slave (
        input  h_sync, v_sync, red, green, blue,
        output x_loc, y_loc, pix_valid, locked, frame_done, err_count, checksum
    );
endinterface

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: watches a VGA sync/colour stream on the pixel clock,
// recovers the active-area coordinate, verifies line and frame periods
// against the parameters and tracks lock (SEARCH -> VERIFY -> LOCKED).
// Optional feature: define VGA_MON_CHECKSUM_EN to publish a per-frame sum of
// the visible pixel colours on checksum; otherwise checksum is tied to 0.
module vga_timing_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic                clk,
    input  logic                reset,
    vga_timing_monitor_if.slave vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // A good line ends with hcnt = H_TOTAL-1 at the next hsync fall; same for frames.
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    logic       hs_reg, vs_reg, hs_prev_reg, vs_prev_reg;
    logic [9:0] hcnt_reg, vcnt_reg;
    logic       line_bad_reg;
    state_t     state_reg, state_next;
    logic       frame_done_reg, frame_done_next;
    logic       lose_lock;
    logic [7:0] err_count_reg;
    logic [9:0] x_loc_reg, y_loc_reg;
    logic       pix_valid_reg;

    logic hs_fall, vs_fall;
    logic line_fail, frame_ok, sync_lost, visible;

    assign hs_fall   = hs_prev_reg & ~hs_reg;
    assign vs_fall   = vs_prev_reg & ~vs_reg;
    assign line_fail = hs_fall && (hcnt_reg != H_LAST);
    assign frame_ok  = (vcnt_reg == V_LAST);
    assign sync_lost = (hcnt_reg == CNT_MAX);
    assign visible   = (hcnt_reg >= H_START) && (hcnt_reg <= H_END) &&
                       (vcnt_reg >= V_START) && (vcnt_reg <= V_END);

    // Register the syncs once and keep one sample of history for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
            hs_prev_reg <= 1'b1;
            vs_prev_reg <= 1'b1;
        end else begin
            hs_reg      <= vga.h_sync;
            vs_reg      <= vga.v_sync;
            hs_prev_reg <= hs_reg;
            vs_prev_reg <= vs_reg;
        end
    end

    // Position counters re-aligned by the sync falls; line_bad remembers a bad line within the frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hcnt_reg     <= '0;
            vcnt_reg     <= '0;
            line_bad_reg <= 1'b0;
        end else begin
            if (hs_fall)
                hcnt_reg <= '0;
            else if (hcnt_reg != CNT_MAX)
                hcnt_reg <= hcnt_reg + 10'd1;

            // A vsync fall wins over a coincident hsync fall so the frame starts at line 0.
            if (vs_fall)
                vcnt_reg <= '0;
            else if (hs_fall && (vcnt_reg != CNT_MAX))
                vcnt_reg <= vcnt_reg + 10'd1;

            if (vs_fall)
                line_bad_reg <= 1'b0;
            else if (line_fail)
                line_bad_reg <= 1'b1;
        end
    end

    // Lock tracking: a line check failing on the frame's last hsync fall also blocks the lock.
    always_comb begin
        state_next      = state_reg;
        lose_lock       = 1'b0;
        frame_done_next = 1'b0;
        case (state_reg)
            SEARCH: begin
                if (vs_fall)
                    state_next = VERIFY;
            end
            VERIFY: begin
                if (vs_fall && !line_bad_reg && !line_fail && frame_ok)
                    state_next = LOCKED;
            end
            LOCKED: begin
                if (line_fail || sync_lost || (vs_fall && !frame_ok)) begin
                    state_next = SEARCH;
                    lose_lock  = 1'b1;
                end else if (vs_fall) begin
                    frame_done_next = 1'b1;
                end
            end
            default: begin
                state_next = SEARCH;
            end
        endcase
    end

    // State register, lock-loss counter and the registered coordinate outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= SEARCH;
            frame_done_reg <= 1'b0;
            err_count_reg  <= '0;
            x_loc_reg      <= '0;
            y_loc_reg      <= '0;
            pix_valid_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_done_reg <= frame_done_next;
            if (lose_lock && (err_count_reg != 8'hFF))
                err_count_reg <= err_count_reg + 8'd1;
            x_loc_reg     <= visible ? (hcnt_reg - H_START) : 10'd0;
            y_loc_reg     <= visible ? (vcnt_reg - V_START) : 10'd0;
            pix_valid_reg <= visible && (state_reg == LOCKED);
        end
    end

    assign vga.x_loc      = x_loc_reg;
    assign vga.y_loc      = y_loc_reg;
    assign vga.pix_valid  = pix_valid_reg;
    assign vga.locked     = (state_reg == LOCKED);
    assign vga.frame_done = frame_done_reg;
    assign vga.err_count  = err_count_reg;

`ifdef VGA_MON_CHECKSUM_EN
    logic [11:0] col_reg, col_d_reg;
    logic [15:0] accum_reg, checksum_reg;

    // Delay the colour two stages so it lines up with hcnt/vcnt.
    always_ff @(posedge clk) begin
        if (!reset) begin
            col_reg   <= '0;
            col_d_reg <= '0;
        end else begin
            col_reg   <= {vga.red, vga.green, vga.blue};
            col_d_reg <= col_reg;
        end
    end

    // Sum visible pixels while verifying or locked; publish and restart at each frame start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            accum_reg    <= '0;
            checksum_reg <= '0;
        end else if (vs_fall) begin
            checksum_reg <= accum_reg;
            accum_reg    <= '0;
        end else if (lose_lock) begin
            accum_reg <= '0;
        end else if (visible && (state_reg != SEARCH)) begin
            accum_reg <= accum_reg + {4'd0, col_d_reg};
        end
    end

    assign vga.checksum = checksum_reg;
`else
    // Colour only feeds the checksum, so it is intentionally left unread here.
    logic unused_colour;
    assign unused_colour = ^{vga.red, vga.green, vga.blue};
    assign vga.checksum  = 16'd0;
`endif

endmodule
